// File: rtl/key_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_pkg
// Description : Shared types and helpers for the time-shared key debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package key_scan_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int c_DEB_CYCLES_DEFAULT = 1048575;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin first-set finder, searching upward from ptr_i with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import key_scan_pkg::*;
#(
    parameter  int N_KEYS = 4,
    localparam int IDX_W  = idx_w(N_KEYS)
) (
    input  logic [N_KEYS-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o
);

    int j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        // Walk offsets downward so the request closest to ptr_i is written last and wins.
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= N_KEYS) begin
                j = j - N_KEYS;
            end
            if (req_i[IDX_W'(j)]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_ctrl
// Description : Key debouncer sharing one counter across N keys, round-robin served.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter  int N_KEYS     = 4,
    parameter  int DEB_CYCLES = c_DEB_CYCLES_DEFAULT,
    parameter  int CNT_W      = 20,
    localparam int IDX_W      = idx_w(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_stable,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              busy,
    output logic [IDX_W-1:0]  cur_idx
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_KEYS - 1);

    state_t              state_q, state_d;
    logic [N_KEYS-1:0]   sync1_q, sync2_q;
    logic [N_KEYS-1:0]   key_stable_q, key_stable_d;
    logic [N_KEYS-1:0]   press_q, press_d;
    logic [N_KEYS-1:0]   release_q, release_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [N_KEYS-1:0]   w_diff;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [IDX_W-1:0]    w_next_ptr;

    assign w_diff     = sync2_q ^ key_stable_q;
    assign w_next_ptr = (cur_idx_q == c_IDX_LAST) ? '0 : cur_idx_q + 1'b1;

    rr_pick #(
        .N_KEYS (N_KEYS)
    ) u_rr_pick (
        .req_i   (w_diff),
        .ptr_i   (rr_ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        cur_idx_d    = cur_idx_q;
        key_stable_d = key_stable_q;
        press_d      = '0;
        release_d    = '0;
        case (state_q)
            IDLE: begin
                if (scan_en && w_pick_valid) begin
                    cur_idx_d = w_pick_idx;
                    cnt_d     = '0;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (!scan_en) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cur_idx_d = '0;
                end else if (sync2_q[cur_idx_q] == key_stable_q[cur_idx_q]) begin
                    // Key bounced back to its committed level: give the next key a turn.
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cur_idx_d = '0;
                    rr_ptr_d  = w_next_ptr;
                end else if (cnt_q == c_CNT_LAST) begin
                    key_stable_d[cur_idx_q] = sync2_q[cur_idx_q];
                    if (sync2_q[cur_idx_q]) begin
                        press_d[cur_idx_q] = 1'b1;
                    end else begin
                        release_d[cur_idx_q] = 1'b1;
                    end
                    state_d   = IDLE;
                    cnt_d     = '0;
                    cur_idx_d = '0;
                    rr_ptr_d  = w_next_ptr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            key_stable_q <= '0;
            press_q      <= '0;
            release_q    <= '0;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            cur_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= key_in;
            sync2_q      <= sync1_q;
            key_stable_q <= key_stable_d;
            press_q      <= press_d;
            release_q    <= release_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_idx_q    <= cur_idx_d;
        end
    end

    assign key_stable    = key_stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign busy          = (state_q == COUNT);
    assign cur_idx       = cur_idx_q;

endmodule
`default_nettype wire
